// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, types and coefficient table for the 71-tap FIR.
//   Sample format  Q1.15  (16b signed)
//   Coefficients   Q2.18  (20b signed), symmetric lowpass, DC gain exactly 1.0
//   Products       35b, 32 fractional bits (full 36b product >>> 1)
//   Accumulator    42b, Q10.32
package fir_pkg;

   localparam int N_TAPS        = 71;
   localparam int DATA_WIDTH    = 16;
   localparam int DATA_FRAC     = 15;
   localparam int COEFF_WIDTH   = 20;
   localparam int COEFF_FRAC    = 18;
   localparam int PRODUCT_WIDTH = 35;
   localparam int PRODUCT_FRAC  = 32;
   localparam int ACC_WIDTH     = 42;
   localparam int ACC_FRAC      = 32;

   localparam int FULL_WIDTH = DATA_WIDTH + COEFF_WIDTH;
   localparam int PROD_SHIFT = DATA_FRAC + COEFF_FRAC - PRODUCT_FRAC;
   localparam int OUT_SHIFT  = ACC_FRAC - DATA_FRAC;

   typedef logic signed [DATA_WIDTH-1:0]    sample_t;
   typedef logic signed [COEFF_WIDTH-1:0]   coeff_t;
   typedef logic signed [FULL_WIDTH-1:0]    full_t;
   typedef logic signed [PRODUCT_WIDTH-1:0] prod_t;
   typedef logic signed [ACC_WIDTH-1:0]     acc_t;

   // Truncated sinc (cutoff fs/8); centre tap trimmed so the taps sum to 2^18.
   localparam coeff_t COEFFS [0:N_TAPS-1] = '{
       20'sd1686,   20'sd2454,   20'sd1788,   20'sd0,     -20'sd1903,
      -20'sd2781,  -20'sd2035,   20'sd0,      20'sd2185,   20'sd3209,
       20'sd2360,   20'sd0,     -20'sd2565,  -20'sd3793,  -20'sd2810,
       20'sd0,      20'sd3106,   20'sd4636,   20'sd3471,   20'sd0,
      -20'sd3934,  -20'sd5960,  -20'sd4539,   20'sd0,      20'sd5364,
       20'sd8344,   20'sd6556,   20'sd0,     -20'sd8429,  -20'sd13907,
      -20'sd11801,  20'sd0,      20'sd19668,  20'sd41722,  20'sd59003,
       20'sd59954,
       20'sd59003,  20'sd41722,  20'sd19668,  20'sd0,     -20'sd11801,
      -20'sd13907, -20'sd8429,   20'sd0,      20'sd6556,   20'sd8344,
       20'sd5364,   20'sd0,     -20'sd4539,  -20'sd5960,  -20'sd3934,
       20'sd0,      20'sd3471,   20'sd4636,   20'sd3106,   20'sd0,
      -20'sd2810,  -20'sd3793,  -20'sd2565,   20'sd0,      20'sd2360,
       20'sd3209,   20'sd2185,   20'sd0,     -20'sd2035,  -20'sd2781,
      -20'sd1903,   20'sd0,      20'sd1788,   20'sd2454,   20'sd1686
   };

endpackage

// File: rtl/fir_sat_round.sv
// fir_sat_round: scales the Q10.32 accumulator down to Q1.15 (floor) and
// clips to the 16-bit signed range.
//   acc        in   accumulator value
//   sample     out  saturated Q1.15 sample
//   overflow   out  result was clipped to 0x7FFF
//   underflow  out  result was clipped to 0x8000
module fir_sat_round
   import fir_pkg::*;
(
   input  acc_t    acc,
   output sample_t sample,
   output logic    overflow,
   output logic    underflow
);

   localparam acc_t SAT_MAX = acc_t'((1 << (DATA_WIDTH - 1)) - 1);
   localparam acc_t SAT_MIN = ~SAT_MAX;

   acc_t shifted;

   always_comb begin
      shifted   = acc >>> OUT_SHIFT;
      sample    = sample_t'(shifted);
      overflow  = 1'b0;
      underflow = 1'b0;
      if (shifted > SAT_MAX) begin
         sample   = sample_t'(SAT_MAX);
         overflow = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sample    = sample_t'(SAT_MIN);
         underflow = 1'b1;
      end
   end

endmodule

// File: rtl/fir_filter.sv
// fir_filter: fixed-coefficient 71-tap direct-form FIR, one sample per clk
// when valid_in, saturating Q1.15 output with overflow/underflow flags.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   fir_in     in   Q1.15 input sample
//   valid_in   in   fir_in valid this cycle (no backpressure)
//   fir_out    out  Q1.15 saturated output (holds between valid_out pulses)
//   valid_out  out  one-cycle pulse per accepted input
//   underflow  out  fir_out was clipped to 0x8000
//   overflow   out  fir_out was clipped to 0x7FFF
// Build option: define FIR_PIPE_EN to register the products before the
// summation (latency 2 clk instead of 1, bit-identical results).
module fir_filter
   import fir_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] fir_in,
   input  logic                         valid_in,
   output logic signed [DATA_WIDTH-1:0] fir_out,
   output logic                         valid_out,
   output logic                         underflow,
   output logic                         overflow
);

   sample_t taps    [1:N_TAPS-1];
   sample_t x       [0:N_TAPS-1];
   prod_t   prod    [0:N_TAPS-1];
   prod_t   sum_src [0:N_TAPS-1];
   acc_t    acc;
   logic    out_en;
   sample_t sat_sample;
   logic    sat_ovf;
   logic    sat_unf;

   // Delay line holds the previous 70 accepted samples; tap 0 is fir_in itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 1; k < N_TAPS; k++) taps[k] <= '0;
      end else if (valid_in) begin
         taps[1] <= fir_in;
         for (int unsigned k = 2; k < N_TAPS; k++) taps[k] <= taps[k-1];
      end
   end

   always_comb begin
      x[0] = fir_in;
      for (int unsigned k = 1; k < N_TAPS; k++) x[k] = taps[k];
   end

   // Full 36b product (frac 33), arithmetic shift drops one LSB to frac 32.
   always_comb begin
      full_t full;
      full = '0;
      for (int unsigned k = 0; k < N_TAPS; k++) begin
         full    = full_t'(x[k]) * full_t'(COEFFS[k]);
         prod[k] = prod_t'(full >>> PROD_SHIFT);
      end
   end

`ifdef FIR_PIPE_EN
   prod_t prod_q [0:N_TAPS-1];
   logic  valid_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
         valid_p <= 1'b0;
      end else begin
         valid_p <= valid_in;
         if (valid_in) begin
            for (int unsigned k = 0; k < N_TAPS; k++) prod_q[k] <= prod[k];
         end
      end
   end

   always_comb begin
      out_en = valid_p;
      for (int unsigned k = 0; k < N_TAPS; k++) sum_src[k] = prod_q[k];
   end
`else
   always_comb begin
      out_en = valid_in;
      for (int unsigned k = 0; k < N_TAPS; k++) sum_src[k] = prod[k];
   end
`endif

   // 42 bits cannot wrap: 71 products of at most 2^33 magnitude.
   always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < N_TAPS; k++) acc = acc + acc_t'(sum_src[k]);
   end

   fir_sat_round u_sat (
      .acc       (acc),
      .sample    (sat_sample),
      .overflow  (sat_ovf),
      .underflow (sat_unf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fir_out   <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         valid_out <= out_en;
         if (out_en) begin
            fir_out   <= sat_sample;
            overflow  <= sat_ovf;
            underflow <= sat_unf;
         end
      end
   end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: self-checking bench for fir_filter (table-driven impulse,
// DC, saturation, gapped random stream, mid-stream reset).
module tb_fir_filter;
   import fir_pkg::*;

`ifdef FIR_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] fir_in;
   logic        valid_in;
   logic [15:0] fir_out;
   logic        valid_out;
   logic        underflow;
   logic        overflow;

   always #5 clk = ~clk;

   fir_filter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fir_in    (fir_in),
      .valid_in  (valid_in),
      .fir_out   (fir_out),
      .valid_out (valid_out),
      .underflow (underflow),
      .overflow  (overflow)
   );

   typedef struct {
      logic [15:0] out;
      logic        ovf;
      logic        unf;
   } exp_t;

   typedef struct {
      logic [15:0] smp;
      logic [15:0] out;
      logic        ovf;
      logic        unf;
   } vec_t;

   int     errors = 0;
   int     checks = 0;
   exp_t   sb[$];
   exp_t   last;
   longint hist [0:N_TAPS-1];
   logic [1:0] vpipe = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: history of accepted samples, sum of per-tap floor(x*c/2), then floor /2^17.
   task automatic model_step(input logic [15:0] s, output exp_t e);
      longint acc, y;
      for (int k = N_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'($signed(s));
      acc = 0;
      for (int k = 0; k < N_TAPS; k++) acc += (hist[k] * longint'(COEFFS[k])) >>> 1;
      y = acc >>> 17;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (y > 32767) begin
         e.out = 16'h7FFF; e.ovf = 1'b1;
      end else if (y < -32768) begin
         e.out = 16'h8000; e.unf = 1'b1;
      end else begin
         e.out = y[15:0];
      end
   endtask

   task automatic drive(input logic [15:0] s, input bit v);
      exp_t e;
      @(posedge clk); #1;
      fir_in   = s;
      valid_in = v;
      if (v) begin
         model_step(s, e);
         sb.push_back(e);
      end
   endtask

   task automatic drive_vec(input vec_t t);
      exp_t e;
      @(posedge clk); #1;
      fir_in   = t.smp;
      valid_in = 1'b1;
      model_step(t.smp, e);
      e.out = t.out; e.ovf = t.ovf; e.unf = t.unf;
      sb.push_back(e);
   endtask

   task automatic flush();
      repeat (LAT + 2) drive(16'h0000, 1'b0);
   endtask

   task automatic expect_out(input string name, input logic [15:0] o, input logic ov, input logic un);
      @(negedge clk);
      check(name, {fir_out, overflow, underflow}, {o, ov, un});
   endtask

   // Cycle monitor: valid_out timing, data against scoreboard, hold between pulses.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         vpipe = '0;
         last  = '{16'h0000, 1'b0, 1'b0};
         check("reset_outputs", {fir_out, valid_out, overflow, underflow}, 32'h0);
      end else begin
         check("valid_out", valid_out, vpipe[LAT-1]);
         if (valid_out) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underrun: valid_out with no expected sample at %0t", $time);
            end else begin
               e = sb.pop_front();
               last = e;
               check("sample", {fir_out, overflow, underflow}, {e.out, e.ovf, e.unf});
            end
         end else begin
            check("hold", {fir_out, overflow, underflow}, {last.out, last.ovf, last.unf});
         end
         vpipe = {vpipe[0], valid_in};
      end
   end

   initial begin
      vec_t        tab [0:79];
      int          c, sumc;
      longint      dc_exp;
      logic [15:0] s;
      bit          v;

      rst_n = 1'b1; valid_in = 1'b0; fir_in = '0;
      for (int k = 0; k < N_TAPS; k++) hist[k] = 0;

      // Impulse table: 0x4000 then zeros; output k is COEFFS[k] floored by 16.
      sumc = 0;
      for (int i = 0; i < 80; i++) begin
         tab[i].smp = (i == 0) ? 16'h4000 : 16'h0000;
         tab[i].ovf = 1'b0;
         tab[i].unf = 1'b0;
         if (i < N_TAPS) begin
            c = int'(COEFFS[i]);
            sumc += c;
            tab[i].out = 16'(c >>> 4);
         end else begin
            tab[i].out = 16'h0000;
         end
      end
      dc_exp = (longint'(16'h2000) * sumc) >>> 18;

      // 1: reset
      #2 rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_hold", {fir_out, valid_out, overflow, underflow}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 2: impulse
      for (int i = 0; i < 80; i++) drive_vec(tab[i]);
      flush();

      // 3: DC
      repeat (100) drive(16'h2000, 1'b1);
      flush();
      expect_out("dc_level", 16'(dc_exp), 1'b0, 1'b0);

      // 4: saturation high then low
      for (int j = 0; j < N_TAPS; j++) begin
         c = int'(COEFFS[N_TAPS - 1 - j]);
         drive((c > 0) ? 16'h7FFF : (c < 0) ? 16'h8001 : 16'h0000, 1'b1);
      end
      flush();
      expect_out("sat_high", 16'h7FFF, 1'b1, 1'b0);
      for (int j = 0; j < N_TAPS; j++) begin
         c = int'(COEFFS[N_TAPS - 1 - j]);
         drive((c > 0) ? 16'h8001 : (c < 0) ? 16'h7FFF : 16'h0000, 1'b1);
      end
      flush();
      expect_out("sat_low", 16'h8000, 1'b0, 1'b1);

      // 5: gapped random stream
      for (int i = 0; i < 1500; i++) begin
         s = 16'($urandom);
         if ($urandom_range(0, 2) != 0) s = {{3{s[15]}}, s[15:3]};
         v = (i % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
         drive(s, v);
      end
      flush();

      // 6: reset mid-stream, then impulse again with no residue
      for (int i = 0; i < 40; i++) drive(16'($urandom), 1'b1);
      @(posedge clk); #3;
      rst_n = 1'b0; valid_in = 1'b0;
      sb.delete();
      for (int k = 0; k < N_TAPS; k++) hist[k] = 0;
      #1 check("reset_async", {fir_out, valid_out, overflow, underflow}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 80; i++) drive_vec(tab[i]);
      flush();

      check("drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
